serial_word_collector: RTL
==========================

# serial_word_collector

Bit-serial to parallel collector sitting directly downstream of the two's complement converter FSM. Accepts the converter's LSB-first serial output one bit per qualified clock, assembles WIDTH-bit words, and presents each completed word on a registered parallel output with a valid/ready handshake. The serial side cannot be stalled. A word that completes while the output register is still unconsumed is dropped and flagged.

## Interface
- WIDTH, 8, word length in bits; legal range 2..32

- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- in  input  1  serial data bit (converter output), LSB first
- in_valid  input  1  qualifies `in` this cycle
- sof  input  1  start-of-frame; meaningful only with in_valid=1; marks `in` as bit 0 of a new word
- out_word  output  WIDTH  last completed word
- out_valid  output  1  out_word holds an unconsumed word
- out_ready  input  1  consumer accepts out_word when out_valid=1
- busy  output  1  partial word in progress (state COLLECT)
- overflow  output  1  one-cycle pulse: completed word dropped
- frame_err  output  1  one-cycle pulse: partial word abandoned by sof

## Operation
- Shift register sr[WIDTH-1:0], bit counter cnt (ceil(log2 WIDTH) bits), FSM states IDLE, COLLECT.
- Accepted bit: sr <= {in, sr[WIDTH-1:1]}, so the first bit ends at sr[0].
- IDLE:
  - in_valid=1 and sof=1: accept bit, cnt <= 1, go to COLLECT.
  - in_valid=1 and sof=0: bit discarded, no flag.
  - in_valid=0: stay.
- COLLECT:
  - in_valid=0: hold sr and cnt.
  - in_valid=1, sof=0, cnt<WIDTH-1: accept bit, cnt++.
  - in_valid=1, sof=0, cnt=WIDTH-1: accept final bit and complete the word, then return to IDLE with cnt <= 0.
  - in_valid=1, sof=1: frame_err pulses. The partial word is discarded. The bit is accepted as bit 0 of a new word, cnt <= 1, and the FSM stays in COLLECT.
- Word completion (the completed word is {in, sr[WIDTH-1:1]}):
  - out_valid=0, or out_valid=1 with out_ready=1: out_word <= completed word, out_valid <= 1.
  - out_valid=1 with out_ready=0: word dropped, out_word unchanged, overflow pulses.
- Handshake: when out_valid=1 and out_ready=1 with no completion that cycle, out_valid <= 0. out_word keeps its value after consumption.
- busy = (state == COLLECT).
- Reset values: out_word 0, out_valid 0, busy 0, overflow 0, frame_err 0, sr 0, cnt 0, state IDLE.

## Timing
- Latency: out_valid rises on the clock edge that samples the final bit, so it is visible the following cycle.
- Back-to-back frames: sof may accompany the bit immediately after a word's final bit. No gap cycle is required, and full throughput is one bit per clock.
- Simultaneous completion and consumption: the new word loads on the same edge, out_valid stays 1, and overflow stays 0.
- overflow and frame_err are registered, high for exactly one cycle after the causing edge.
- Reset asserted mid-word clears the partial word and out_valid at once, with no flag pulses. Collection resumes only after deassertion and a new sof.
- in, sof and out_ready are ignored while reset=1.

## Test plan
- WIDTH=8, reset then stream bits 0,0,1,1,0,1,0,0 with sof on the first bit, one per clock -> out_valid=1 one cycle after the 8th bit; out_word=8'h2C; busy high during bits 2-8 then low.
- Same frame with in_valid deasserted for 3 cycles between bits 4 and 5 -> same 8'h2C. cnt holds during the gap, and out_valid rises only after the 8th accepted bit.
- Two back-to-back frames 8'h2C then 8'hFF with out_ready=0 throughout -> out_word stays 8'h2C, overflow pulses once on completion of the second frame, out_valid stays 1.
- Repeat with out_ready=1 held in the cycle the second frame completes -> out_word=8'hFF, out_valid stays 1, no overflow.
- Start frame, send 5 bits, then sof with bits 1,0,0,0,0,0,0,0 -> frame_err pulses once; out_word=8'h01.
- Assert reset after 4 bits of a frame -> all outputs 0 immediately (asynchronous). A subsequent full frame of all zeros gives out_word=8'h00 with out_valid=1.

Source files
------------

// File: rtl/serial_word_collector_if.sv
// Parallel word handshake between the serial collector and its consumer.
// master: drives out_word/out_valid, samples out_ready; slave: the reverse.
interface serial_word_collector_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] out_word;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_word,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_word,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/serial_word_collector.sv
// Assembles LSB-first serial bits into WIDTH-bit words with a valid/ready output.
// Ports: clk, reset (async high), in/in_valid/sof serial side, out_if word
// handshake, busy (mid-word), overflow and frame_err one-cycle pulses.
module serial_word_collector #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in,
    input  logic                    in_valid,
    input  logic                    sof,
    serial_word_collector_if.master out_if,
    output logic                    busy,
    output logic                    overflow,
    output logic                    frame_err
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t           state_q, state_d;
    // Only the upper WIDTH-1 bits of the shift register are kept: the
    // lowest bit is shifted out on the same edge the word completes, so
    // it is never observed.
    logic [WIDTH-2:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             ferr_q, ferr_d;
    logic [WIDTH-1:0] shifted;
    logic             complete;

    // Shift with the new bit; also the completed word on the final bit.
    assign shifted = {in, sr_q};

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        valid_d  = valid_q;
        ovf_d    = 1'b0;
        ferr_d   = 1'b0;
        complete = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_valid && sof) begin
                    sr_d    = shifted[WIDTH-1:1];
                    cnt_d   = CW'(1);
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (in_valid) begin
                    sr_d = shifted[WIDTH-1:1];
                    if (sof) begin
                        // Restart: stale bits get shifted out by the new word.
                        ferr_d = 1'b1;
                        cnt_d  = CW'(1);
                    end else if (cnt_q == LAST) begin
                        complete = 1'b1;
                        cnt_d    = '0;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (complete) begin
            if (!valid_q || out_if.out_ready) begin
                word_d  = shifted;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && out_if.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            ferr_q  <= ferr_d;
        end
    end

    assign out_if.out_word  = word_q;
    assign out_if.out_valid = valid_q;
    assign busy             = (state_q == COLLECT);
    assign overflow         = ovf_q;
    assign frame_err        = ferr_q;
endmodule
